// File: rtl/ss_ch_arb_pkg.sv
// Shared types and constants for the DMA channel arbiter and its helpers.
package ss_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam int              BEAT_W   = 16;
  localparam logic [BEAT_W-1:0] BEAT_SAT = 16'hFFFF;
  localparam int              TMO_DEF  = 1024;

endpackage

// File: rtl/ss_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, wrapping.
module ss_rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_id,
  output logic           o_vld
);

  logic [IDW-1:0] w_idx;

  // Walk the search order backwards so the nearest candidate to ptr+1 is written last.
  always_comb begin
    o_gnt = '0;
    o_id  = '0;
    o_vld = 1'b0;
    w_idx = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = IDW'((int'(i_ptr) + k) % N);
      if (i_req[w_idx]) begin
        o_gnt        = '0;
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx;
        o_vld        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ss_ch_arb.sv
// Round-robin owner of the shared scatter/gather engine: grants one DMA channel per tenure,
// muxes its control to the engine, demuxes engine strobes back, counts beats, aborts stalls.
//
//   state      | meaning
//   ST_IDLE    | no owner; pick next requester, pulse eng_start
//   ST_GRANT   | channel gnt_id owns the engine
//   ST_RELEASE | tenure over; advance round-robin pointer
module ss_ch_arb
  import ss_arb_pkg::*;
#(
  parameter int NCH = 2,
  parameter int IDW = 1,
  parameter int TMO = TMO_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NCH-1:0]    ch_start,
  input  logic [NCH-1:0]    ch_stop,
  input  logic [NCH-1:0]    ch_end,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH-1:0]    err_clr,
  input  logic              eng_xfer,
  input  logic              eng_last,
  output logic              eng_start,
  output logic              eng_stop,
  output logic              eng_end,
  output logic [NCH-1:0]    ch_xfer,
  output logic [NCH-1:0]    ch_last,
  output logic [NCH-1:0]    gnt,
  output logic [IDW-1:0]    gnt_id,
  output logic              busy,
  output logic [BEAT_W-1:0] beat_cnt,
  output logic [NCH-1:0]    tmo_err
);

  localparam int TW = $clog2(TMO);

  arb_state_t        r_state;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_gnt_id;
  logic [NCH-1:0]    r_gnt;
  logic [NCH-1:0]    r_tmo_err;
  logic              r_eng_start;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [TW-1:0]     r_idle_cnt;

  logic [NCH-1:0]    w_pick_oh;
  logic [IDW-1:0]    w_pick_id;
  logic              w_pick_vld;
  logic              w_in_grant;
  logic              w_last;
  logic              w_end;
  logic              w_tmo;
  logic              w_exit;

  ss_rr_pick #(
    .N   (NCH),
    .IDW (IDW)
  ) u_pick (
    .i_req (ch_start & ch_en),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_oh),
    .o_id  (w_pick_id),
    .o_vld (w_pick_vld)
  );

  assign w_in_grant = (r_state == ST_GRANT);
  assign w_last     = eng_xfer & eng_last;
  assign w_end      = ch_end[r_gnt_id];
  // A beat on the terminal idle cycle keeps the tenure alive.
  assign w_tmo      = !eng_xfer && (r_idle_cnt == TW'(TMO - 1));
  assign w_exit     = w_last | w_end | w_tmo;

  assign eng_stop  = w_in_grant & ch_stop[r_gnt_id];
  assign eng_end   = w_in_grant & w_end;
  assign ch_xfer   = w_in_grant ? (r_gnt & {NCH{eng_xfer}}) : '0;
  assign ch_last   = w_in_grant ? (r_gnt & {NCH{eng_last}}) : '0;
  assign eng_start = r_eng_start;
  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign busy      = (r_state != ST_IDLE);
  assign beat_cnt  = r_beat_cnt;
  assign tmo_err   = r_tmo_err;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_ptr       <= IDW'(NCH - 1);
      r_gnt_id    <= '0;
      r_gnt       <= '0;
      r_tmo_err   <= '0;
      r_eng_start <= 1'b0;
      r_beat_cnt  <= '0;
      r_idle_cnt  <= '0;
    end else begin
      r_eng_start <= 1'b0;
      r_tmo_err   <= (r_tmo_err & ~err_clr) | ((w_in_grant && w_tmo) ? r_gnt : '0);
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_gnt       <= w_pick_oh;
            r_gnt_id    <= w_pick_id;
            r_eng_start <= 1'b1;
            r_beat_cnt  <= '0;
            r_idle_cnt  <= '0;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (eng_xfer) begin
            r_idle_cnt <= '0;
            if (r_beat_cnt != BEAT_SAT) r_beat_cnt <= r_beat_cnt + 1'b1;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
          if (w_exit) begin
            r_gnt   <= '0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          r_ptr   <= r_gnt_id;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ss_ch_arb.sv
// Scoreboard bench for ss_ch_arb (NCH=2, TMO=8): grants and tenure releases are checked by a monitor.
module tb_ss_ch_arb;

  typedef struct {
    int ch;
    int beats;
    int tmo;
  } rel_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ch_start = '0, ch_stop = '0, ch_end = '0, ch_en = 2'b11, err_clr = '0;
  logic        eng_xfer = 1'b0, eng_last = 1'b0;
  logic        eng_start, eng_stop, eng_end, busy;
  logic [1:0]  ch_xfer, ch_last, gnt, tmo_err;
  logic [0:0]  gnt_id;
  logic [15:0] beat_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   gq[$];
  rel_t rq[$];

  always #5 clk = ~clk;

  ss_ch_arb #(.NCH(2), .IDW(1), .TMO(8)) dut (
    .wb_clk_i (clk),      .wb_rst_i (rst),
    .ch_start (ch_start), .ch_stop  (ch_stop),  .ch_end  (ch_end),
    .ch_en    (ch_en),    .err_clr  (err_clr),
    .eng_xfer (eng_xfer), .eng_last (eng_last),
    .eng_start(eng_start),.eng_stop (eng_stop), .eng_end (eng_end),
    .ch_xfer  (ch_xfer),  .ch_last  (ch_last),
    .gnt      (gnt),      .gnt_id   (gnt_id),   .busy    (busy),
    .beat_cnt (beat_cnt), .tmo_err  (tmo_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rel(input int ch, input int beats, input int tmo);
    rel_t e;
    e.ch = ch; e.beats = beats; e.tmo = tmo;
    rq.push_back(e);
  endtask

  task automatic wait_grant(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!eng_start && cnt < 30);
    check("grant_seen", 32'(eng_start), 1);
  endtask

  // Drives nbeats engine beats starting in the first GRANT cycle; the last one carries eng_last.
  task automatic run_tenure(input int ch, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      eng_xfer = 1'b1;
      eng_last = (b == nbeats - 1);
      #2;
      check("ch_xfer", 32'(ch_xfer), 32'(1 << ch));
      check("ch_last", 32'(ch_last), (b == nbeats - 1) ? 32'(1 << ch) : 0);
      if (b > 0) check("start_pulse", 32'(eng_start), 0);
      tick();
    end
    eng_xfer = 1'b0;
    eng_last = 1'b0;
  endtask

  // Monitor: every engine start and every RELEASE cycle is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (eng_start) begin
        if (gq.size() == 0) check("unexpected_grant", 32'(gnt_id), 32'hFFFF);
        else begin
          int e;
          e = gq.pop_front();
          check("gnt_id", 32'(gnt_id), 32'(e));
          check("gnt_onehot", 32'(gnt), 32'(1 << e));
        end
      end
      if (busy && gnt == 2'b00) begin
        if (rq.size() == 0) check("unexpected_release", 32'(beat_cnt), 32'hFFFF_FFFF);
        else begin
          rel_t r;
          r = rq.pop_front();
          check("rel_beats", 32'(beat_cnt), 32'(r.beats));
          check("rel_tmo_err", 32'(tmo_err[r.ch]), 32'(r.tmo));
        end
      end
    end
  end

  initial begin
    int cnt;
    int exp_ch;
    #22;
    rst = 1'b0;
    tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_gnt_id", 32'(gnt_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_beat_cnt", 32'(beat_cnt), 0);
    check("rst_tmo_err", 32'(tmo_err), 0);
    check("rst_comb", 32'({eng_start, eng_stop, eng_end, ch_xfer, ch_last}), 0);

    // Single request on ch0, three beats.
    gq.push_back(0); push_rel(0, 3, 0);
    ch_start = 2'b01;
    wait_grant(cnt);
    check("req_latency", 32'(cnt), 1);
    ch_start = 2'b00;
    run_tenure(0, 3);
    check("single_gnt_dropped", 32'(gnt), 0);
    tick();

    // Round-robin from reset: 0,1,0,1; next grant arrives L+3 after the final beat.
    rst = 1'b1; tick(); rst = 1'b0;
    ch_start = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_ch = i % 2;
      gq.push_back(exp_ch); push_rel(exp_ch, 2, 0);
      wait_grant(cnt);
      if (i == 3) ch_start = 2'b00;
      if (i > 0) check("rr_gap", 32'(cnt), 2);
      run_tenure(exp_ch, 2);
    end
    tick();

    // Masking: ch0 would be next but is disabled; disabling ch1 mid-tenure is ignored.
    ch_en = 2'b10; ch_start = 2'b11;
    gq.push_back(1); push_rel(1, 4, 0);
    wait_grant(cnt);
    ch_start = 2'b00; ch_en = 2'b00;
    run_tenure(1, 4);
    ch_en = 2'b11;
    tick();

    // Passthrough of stop/end for ch1, with final beat and ch_end on the same cycle.
    ch_start = 2'b10;
    gq.push_back(1); push_rel(1, 2, 0);
    wait_grant(cnt);
    ch_start = 2'b00;
    ch_stop = 2'b10; #2;
    check("stop_granted", 32'(eng_stop), 1);
    ch_stop = 2'b01; #1;
    check("stop_other", 32'(eng_stop), 0);
    eng_xfer = 1'b1;
    tick();
    ch_stop = 2'b00; ch_end = 2'b10; eng_last = 1'b1; #2;
    check("end_granted", 32'(eng_end), 1);
    tick();
    check("end_exit_gnt", 32'(gnt), 0);
    check("end_outside_grant", 32'(eng_end), 0);
    check("xfer_dropped", 32'(ch_xfer), 0);
    tick();
    ch_end = 2'b00; eng_xfer = 1'b0; eng_last = 1'b0;
    check("beat_hold", 32'(beat_cnt), 2);

    // Timeout: eight idle GRANT cycles, then write-1 clear.
    ch_start = 2'b01;
    gq.push_back(0); push_rel(0, 0, 1);
    wait_grant(cnt);
    ch_start = 2'b00;
    cnt = 0;
    while (gnt != 2'b00 && cnt < 20) begin
      tick();
      cnt++;
    end
    check("tmo_cycles", 32'(cnt), 8);
    check("tmo_set", 32'(tmo_err), 32'b01);
    err_clr = 2'b01; tick(); err_clr = 2'b00;
    check("tmo_clr", 32'(tmo_err), 0);

    // Set and clear in the same cycle: set wins.
    ch_start = 2'b01;
    gq.push_back(0); push_rel(0, 0, 1);
    wait_grant(cnt);
    ch_start = 2'b00;
    repeat (7) tick();
    err_clr = 2'b11;
    tick();
    err_clr = 2'b00;
    check("tmo_set_over_clr", 32'(tmo_err), 32'b01);
    err_clr = 2'b01; tick(); err_clr = 2'b00;
    check("tmo_clr2", 32'(tmo_err), 0);

    // A beat on the terminal idle cycle prevents the abort.
    ch_start = 2'b01;
    gq.push_back(0); push_rel(0, 2, 0);
    wait_grant(cnt);
    ch_start = 2'b00;
    repeat (7) tick();
    eng_xfer = 1'b1;
    tick();
    eng_xfer = 1'b0;
    check("tmo_xfer_wins_gnt", 32'(gnt), 32'b01);
    check("tmo_xfer_wins_err", 32'(tmo_err), 0);
    eng_xfer = 1'b1; eng_last = 1'b1;
    tick();
    eng_xfer = 1'b0; eng_last = 1'b0;
    tick();

    // Asynchronous reset in the middle of a ch1 tenure.
    ch_start = 2'b10;
    gq.push_back(1);
    wait_grant(cnt);
    ch_start = 2'b00; ch_stop = 2'b10;
    repeat (5) begin
      eng_xfer = 1'b1;
      tick();
    end
    eng_xfer = 1'b0; #1;
    check("pre_rst_beats", 32'(beat_cnt), 5);
    check("pre_rst_stop", 32'(eng_stop), 1);
    rst = 1'b1; #1;
    check("arst_gnt", 32'(gnt), 0);
    check("arst_gnt_id", 32'(gnt_id), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_beats", 32'(beat_cnt), 0);
    check("arst_eng", 32'({eng_start, eng_stop, eng_end}), 0);
    ch_stop = 2'b00;
    tick();
    rst = 1'b0;
    ch_start = 2'b11;
    gq.push_back(0); push_rel(0, 1, 0);
    wait_grant(cnt);
    ch_start = 2'b00;
    run_tenure(0, 1);
    repeat (3) tick();

    check("grant_queue_empty", 32'(gq.size()), 0);
    check("release_queue_empty", 32'(rq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ss_ch_arb.md
# ss_ch_arb

Round-robin arbiter and sequencer that shares one scatter/gather transfer engine among NCH DMA channels. It sits between the per-channel `ch` instances and the shared engine. It grants one channel at a time and issues the engine start pulse. For the granted channel it passes start/stop/end control to the engine and routes the engine's xfer/last strobes back to that channel only. It also counts beats per tenure and aborts stalled tenures on timeout.

## Interface
Parameters:
- NCH, 2: number of channels (2..8).
- IDW, 1: width of gnt_id, $clog2(NCH) (minimum 1).
- TMO, 1024: idle cycles in GRANT before abort (≥2).

Ports:
- wb_clk_i  in  1  single clock for the block.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- ch_start  in  NCH  per-channel transfer request; level, held until granted.
- ch_stop  in  NCH  per-channel backpressure.
- ch_end  in  NCH  per-channel early-end request.
- ch_en  in  NCH  per-channel enable mask.
- err_clr  in  NCH  write-1 clear for tmo_err bits.
- eng_xfer  in  1  engine moved one beat.
- eng_last  in  1  qualifies eng_xfer as the final beat.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_stop  out  1  stop to the engine.
- eng_end  out  1  end to the engine.
- ch_xfer  out  NCH  eng_xfer routed to the granted channel.
- ch_last  out  NCH  eng_last routed to the granted channel.
- gnt  out  NCH  one-hot grant.
- gnt_id  out  IDW  binary index of the granted channel.
- busy  out  1  state is not IDLE.
- beat_cnt  out  16  beats in the current or most recent tenure.
- tmo_err  out  NCH  sticky timeout flags.

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - Candidate vector is ch_start & ch_en.
  - If nonzero, pick the first set bit searching upward from ptr+1 modulo NCH.
  - Register gnt/gnt_id, pulse eng_start, clear beat_cnt to 0, then go to GRANT.
- GRANT, with g = gnt_id:
  - eng_stop = ch_stop[g] and eng_end = ch_end[g] (combinational).
  - ch_xfer[g] = eng_xfer and ch_last[g] = eng_last. All other ch_xfer/ch_last bits are 0.
  - beat_cnt increments on eng_xfer and saturates at 0xFFFF.
  - Idle counter clears on eng_xfer, otherwise increments.
  - Exit to RELEASE when any of these holds: eng_xfer&eng_last, ch_end[g], or idle counter reaches TMO-1 (this also sets tmo_err[g]).
  - ch_en[g] deasserting mid-tenure is ignored; the tenure runs to completion.
- RELEASE:
  - gnt = 0, eng_stop = 0, eng_end = 0.
  - ptr <= g. Next state is IDLE unconditionally.
- eng_stop, eng_end, ch_xfer and ch_last are 0 outside GRANT. Engine strobes arriving outside GRANT are dropped.
- tmo_err:
  - set has priority over err_clr in the same cycle;
  - err_clr bits for other channels apply normally.
- beat_cnt holds its value in RELEASE and IDLE until the next grant.

## Timing
- Reset values: state IDLE, ptr = NCH-1 (so channel 0 wins first), gnt 0, gnt_id 0, eng_start 0, busy 0, beat_cnt 0, tmo_err 0, idle counter 0. All combinational outputs are 0.
- Request latency: ch_start sampled high at cycle N in IDLE → gnt, gnt_id and eng_start are valid at N+1. eng_start is high for exactly cycle N+1.
- Release latency: final beat, ch_end or timeout at cycle L → RELEASE at L+1, IDLE at L+2, earliest next gnt at L+3.
- Simultaneous eng_xfer&eng_last and ch_end: one exit, beat counted, no error.
- Timeout with eng_xfer on the same cycle: the xfer wins, the counter clears and there is no abort.
- Reset mid-tenure: all outputs drop immediately (asynchronous), and ptr returns to NCH-1.

## Structure
- Package ss_arb_pkg holds:
  - state enum {IDLE, GRANT, RELEASE};
  - beat_cnt width constant (16) and saturation value;
  - default TMO.
- Sub-module ss_rr_pick is combinational. It takes a request vector and ptr and returns the one-hot and binary winner, plus a valid flag. It is reusable by other arbiters in the design.
- Everything else (FSM, counters, mux/demux, error flags) lives in ss_ch_arb.

## Test plan
- Single request: ch_start=2'b01 at N → gnt=01 and eng_start pulse at N+1. Three eng_xfer beats with last on the third → ch_xfer[0] pulses 3×, beat_cnt=3, gnt=0 at the following cycle.
- Round-robin: ch_start=2'b11 held → tenures granted 0,1,0,1 with gap L+3 between the final beat and the next gnt. ch_xfer[1] stays 0 during ch0 tenures.
- Masking: ch_start=2'b11, ch_en=2'b10 → only ch1 is granted. Deasserting ch_en[1] mid-tenure does not shorten the tenure.
- Passthrough: during a ch1 grant, ch_stop[1]=1 → eng_stop=1 the same cycle. ch_stop[0]=1 → eng_stop stays 0. ch_end[1] → eng_end=1 and exit to RELEASE next cycle.
- Timeout with TMO=8: grant ch0 with no eng_xfer → RELEASE after 8 GRANT cycles, tmo_err=01. err_clr=01 → tmo_err=00 next cycle. Set and clear in the same cycle → stays 1.
- Reset mid-tenure: assert wb_rst_i during GRANT with beat_cnt=5 → gnt, busy, beat_cnt and eng_* go to 0 asynchronously. After release, channel 0 is granted first.
